// File: rtl/rr_arbiter8_pkg.sv
// Shared types and the round-robin search helper for the 8-way arbiter.
package rr_arbiter8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned GID_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [GID_W-1:0] id;
  } pick_t;

  // Rotate req so ptr sits at bit 0, take the lowest set bit, rotate the index back.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [GID_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    pick_t              p;
    dbl = {req, req};
    rot = N_REQ'(dbl >> ptr);
    p   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        p.found = 1'b1;
        p.id    = GID_W'(i);
      end
    end
    p.id = GID_W'(p.id + ptr);
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter8_decoder3to8.sv
// Binary index to one-hot decode used to form the grant vector.
module decoder3to8
  import rr_arbiter8_pkg::*;
(
  input  logic [GID_W-1:0] id,
  output logic [N_REQ-1:0] onehot_c
);

  assign onehot_c = N_REQ'(1) << id;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a bounded hold time per owner.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [GID_W-1:0] grant_id,
  output logic             grant_valid
);

  localparam int unsigned      HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [GID_W-1:0] gid_nxt;
  logic             gv_nxt;
  logic [GID_W-1:0] ptr, ptr_nxt;
  logic [HCW-1:0]   hold_cnt, hold_nxt;
  logic             rearb;
  pick_t            pick;
  logic [N_REQ-1:0] dec_c;

  assign pick = rr_pick(req, ptr);

  // Next owner: arbitrate from idle, on release, or when the hold budget is spent.
  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    gv_nxt    = grant_valid;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    rearb     = 1'b0;

    case (state)
      IDLE:    rearb = 1'b1;
      OWNED: begin
        if (!req[grant_id] || (hold_cnt == HOLD_LAST)) begin
          rearb = 1'b1;
        end else begin
          hold_nxt = HCW'(hold_cnt + 1'b1);
        end
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      hold_nxt = '0;
      if (pick.found) begin
        state_nxt = OWNED;
        gid_nxt   = pick.id;
        gv_nxt    = 1'b1;
        ptr_nxt   = GID_W'(pick.id + 1'b1);
      end else begin
        state_nxt = IDLE;
        gid_nxt   = '0;
        gv_nxt    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant_id    <= gid_nxt;
      grant_valid <= gv_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

  decoder3to8 u_dec (
    .id       (grant_id),
    .onehot_c (dec_c)
  );

  assign grant = dec_c & {N_REQ{grant_valid}};

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized and directed checks of rr_arbiter8 (MAX_HOLD=4 and MAX_HOLD=1) against a queue-free model.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] g4, g1;
  logic [2:0] id4, id1;
  logic       v4, v1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .grant(g4), .grant_id(id4), .grant_valid(v4)
  );

  rr_arbiter8 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .grant(g1), .grant_id(id1), .grant_valid(v1)
  );

  // Model: per instance, who owns, how long they've held, and where the next search starts.
  int mh[2] = '{4, 1};
  bit mv[2];
  int mo[2];
  int mc[2];
  int ms[2];
  bit live = 1'b0;

  task automatic model_step(input int u);
    bit found;
    int j;
    if (rst) begin
      mv[u] = 1'b0; mo[u] = 0; mc[u] = 0; ms[u] = 0;
    end else if (!mv[u] || !req[mo[u]] || (mc[u] == mh[u] - 1)) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        j = (ms[u] + k) % 8;
        if (!found && req[j]) begin
          found = 1'b1;
          mo[u] = j;
        end
      end
      mc[u] = 0;
      if (found) begin
        mv[u] = 1'b1;
        ms[u] = (mo[u] + 1) % 8;
      end else begin
        mv[u] = 1'b0;
        mo[u] = 0;
      end
    end else begin
      mc[u] = mc[u] + 1;
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) model_step(u);
    if (rst) live = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [11:0] pack_exp(input int u);
    logic [7:0] g;
    g = mv[u] ? (8'd1 << mo[u]) : 8'd0;
    return {g, mv[u] ? 3'(mo[u]) : 3'd0, mv[u]};
  endfunction

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    if (live) begin
      check("model_h4", {g4, id4, v4}, 32'(pack_exp(0)));
      check("model_h1", {g1, id1, v1}, 32'(pack_exp(1)));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_state", {g4, id4, v4}, 32'h0);
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      check("idle_no_req", {g4, v4}, 32'h0);
    end

    req = 8'h24;
    @(negedge clk);
    check("first_grant", {g4, id4}, {8'h04, 3'd2});
    repeat (2) begin
      @(negedge clk);
      check("hold_grant", 32'(g4), 32'h04);
    end
    req = 8'h20;
    @(negedge clk);
    check("release_no_bubble", {g4, id4, v4}, {8'h20, 3'd5, 1'b1});

    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      check("rotate_h4", {id4, v4}, {3'((k / 4) % 8), 1'b1});
      check("rotate_h1", 32'(id1), 32'(k % 8));
    end

    do_reset();
    req = 8'h40;
    repeat (12) begin
      @(negedge clk);
      check("self_regrant", {g4, g1}, {8'h40, 8'h40});
    end

    do_reset();
    req = 8'h08;
    @(negedge clk);
    check("owner3", 32'(g4), 32'h08);
    req = 8'h0A;
    @(negedge clk);
    check("no_preempt", 32'(g4), 32'h08);
    req = 8'h02;
    @(negedge clk);
    check("after_release", 32'(g4), 32'h02);

    do_reset();
    req = 8'h10;
    @(negedge clk);
    check("pre_reset", 32'(g4), 32'h10);
    rst = 1'b1;
    @(negedge clk);
    check("reset_drop", {g4, id4, v4}, 32'h0);
    rst = 1'b0;
    req = 8'h90;
    @(negedge clk);
    check("search_from_0", 32'(g4), 32'h10);
    req = 8'h80;
    @(negedge clk);
    check("post_reset_release", 32'(g4), 32'h80);

    req = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 99) == 0) req = 8'($urandom);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
